// File: rtl/id_fetch_queue_pkg.sv
// Front-end shared types for the fetch-to-decode instruction queue.
// Holds the queue entry layout, default depth and exception-cause width.
package id_fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH = 8;
  localparam int unsigned EXC_W    = 7;
  localparam int unsigned NCAUSE   = 2;

  // 32+32+1+32+1+2*7 = 112 bits per entry
  typedef struct packed {
    logic [31:0]                  pc;
    logic [31:0]                  inst;
    logic                         pre_taken;
    logic [31:0]                  pre_addr;
    logic                         is_exception;
    logic [NCAUSE-1:0][EXC_W-1:0] exception_cause;
  } fq_entry_t;

  function automatic logic [1:0] pop2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/id_fetch_queue_ram.sv
// Entry storage: DEPTH x fq_entry_t, two write ports, two async reads.
// Ports: clk_i, we0/1_i + waddr0/1_i + wdata0/1_i, raddr0/1_i -> rdata0/1_o.
module id_fetch_queue_ram
  import id_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we0_i,
  input  logic [AW-1:0] waddr0_i,
  input  fq_entry_t     wdata0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] waddr1_i,
  input  fq_entry_t     wdata1_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output fq_entry_t     rdata0_o,
  output fq_entry_t     rdata1_o
);

  fq_entry_t mem_q [DEPTH];

  // Write addresses are always tail and tail+1, so they never collide.
  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/id_fetch_queue.sv
// Two-wide fetch queue between the fetch buffer and decode.
// Ports: cpu_clk/cpu_rst, flush/pause, in_* packet, dec_accept, out_* slots, count.
module id_fetch_queue
  import id_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic                              cpu_clk,
  input  logic                              cpu_rst,
  input  logic                              flush,
  input  logic                              pause,
  input  logic                              in_valid,
  input  logic [1:0]                        in_lane_en,
  input  logic [1:0][31:0]                  in_pc,
  input  logic [1:0][31:0]                  in_inst,
  input  logic [1:0]                        in_pre_taken,
  input  logic [1:0][31:0]                  in_pre_addr,
  input  logic [1:0]                        in_is_exception,
  input  logic [1:0][NCAUSE-1:0][EXC_W-1:0] in_exception_cause,
  output logic                              get_data_req,
  input  logic [1:0]                        dec_accept,
  output logic [1:0]                        out_valid,
  output logic [1:0][31:0]                  out_pc,
  output logic [1:0][31:0]                  out_inst,
  output logic [1:0]                        out_pre_taken,
  output logic [1:0][31:0]                  out_pre_addr,
  output logic [1:0]                        out_is_exception,
  output logic [1:0][NCAUSE-1:0][EXC_W-1:0] out_exception_cause,
  output logic [CW-1:0]                     count
);

  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  fq_entry_t lane_e [2];
  fq_entry_t wdata0, rd0, rd1;
  logic      enq, we0, we1;
  logic [1:0] nenq, ndeq, acc;

  for (genvar l = 0; l < 2; l++) begin : g_lane
    assign lane_e[l] = '{
      pc:              in_pc[l],
      inst:            in_inst[l],
      pre_taken:       in_pre_taken[l],
      pre_addr:        in_pre_addr[l],
      is_exception:    in_is_exception[l],
      exception_cause: in_exception_cause[l]
    };
  end

  assign get_data_req = (({1'b0, count_q} + (CW+1)'(2)) <= DEPTH_L)
                        && !flush;

  assign enq  = in_valid && get_data_req;
  assign nenq = enq ? pop2(in_lane_en) : 2'd0;

  // Lanes are packed from tail: a lone lane1 lands on write port 0.
  assign we0    = enq && |in_lane_en;
  assign we1    = enq && &in_lane_en;
  assign wdata0 = in_lane_en[0] ? lane_e[0] : lane_e[1];

  assign out_valid[0] = (count_q >= CW'(1)) && !pause && !flush;
  assign out_valid[1] = (count_q >= CW'(2)) && !pause && !flush;

  // Accepting slot1 without slot0 is illegal; treat it as no accept.
  assign acc  = dec_accept & out_valid;
  assign ndeq = (acc == 2'b11) ? 2'd2 :
                (acc == 2'b01) ? 2'd1 : 2'd0;

  always_comb begin
    head_d  = head_q + AW'(ndeq);
    tail_d  = tail_q + AW'(nenq);
    count_d = count_q + CW'(nenq) - CW'(ndeq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  id_fetch_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i    (cpu_clk),
    .we0_i    (we0),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (tail_q + AW'(1)),
    .wdata1_i (lane_e[1]),
    .raddr0_i (head_q),
    .raddr1_i (head_q + AW'(1)),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

  assign out_pc[0]              = rd0.pc;
  assign out_pc[1]              = rd1.pc;
  assign out_inst[0]            = rd0.inst;
  assign out_inst[1]            = rd1.inst;
  assign out_pre_taken[0]       = rd0.pre_taken;
  assign out_pre_taken[1]       = rd1.pre_taken;
  assign out_pre_addr[0]        = rd0.pre_addr;
  assign out_pre_addr[1]        = rd1.pre_addr;
  assign out_is_exception[0]    = rd0.is_exception;
  assign out_is_exception[1]    = rd1.is_exception;
  assign out_exception_cause[0] = rd0.exception_cause;
  assign out_exception_cause[1] = rd1.exception_cause;

  assign count = count_q;

endmodule

// File: doc/id_fetch_queue.md
ID_FETCH_QUEUE -- requirements
Module: id_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 4.
REQ-002 SHALL have ports, clock and reset first:
  cpu_clk  in  1  sole clock, all state updates on rising edge
  cpu_rst  in  1  synchronous reset, active-high
  flush  in  1  discard all entries (driven from fb_flush[1])
  pause  in  1  hold outputs, no dequeue (driven from fb_pause[1])
  in_valid  in  1  fetch packet present (driven from fb_valid)
  in_lane_en  in  2  per-lane valid within packet; lane0 written before lane1
  in_pc  in  2x32  per-lane pc
  in_inst  in  2x32  per-lane instruction
  in_pre_taken  in  2  per-lane predicted taken
  in_pre_addr  in  2x32  per-lane predicted target
  in_is_exception  in  2  per-lane exception flag
  in_exception_cause  in  2x2x7  per-lane exception causes
  get_data_req  out  1  request to front: space for a full packet
  dec_accept  in  2  decode consumes slot0 / slot0+slot1 (legal: 00, 01, 11)
  out_valid  out  2  slot valid, slot0 = oldest
  out_pc, out_inst, out_pre_taken, out_pre_addr, out_is_exception, out_exception_cause  out  per-slot copies of in_* widths
  count  out  log2(DEPTH)+1  occupied entries

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH entries, each holding pc, inst, pre_taken, pre_addr, is_exception, exception_cause (112 bits).
REQ-004 head and tail pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be tracked separately, never via pointer compare.
REQ-005 get_data_req SHALL be combinational: 1 iff count + 2 <= DEPTH and flush = 0.
REQ-006 Enqueue SHALL occur when in_valid = 1 and get_data_req = 1; number written = popcount(in_lane_en); enabled lanes packed contiguously from tail in lane order (lane_en=10 writes lane1 at tail).
REQ-007 in_valid while get_data_req = 0 SHALL be ignored (no write, no overflow).
REQ-008 out_valid[0] SHALL be count >= 1 and pause = 0 and flush = 0; out_valid[1] SHALL be count >= 2 and pause = 0 and flush = 0.
REQ-009 Output payloads SHALL be combinational reads of entries head and head+1 (mod DEPTH); zero latency from stored entry to output.
REQ-010 Dequeue count SHALL be popcount(dec_accept & out_valid); dec_accept = 10 SHALL be treated as 00.
REQ-011 Simultaneous enqueue and dequeue in one cycle SHALL both take effect; next count = count + nenq - ndeq.
REQ-012 Written entries SHALL be readable at the outputs the cycle after the write (no bypass from in_* to out_*).
REQ-013 flush SHALL take priority over enqueue and dequeue: next cycle head = tail = 0, count = 0; in that cycle no write and no dequeue.
REQ-014 pause SHALL freeze head; enqueue continues per REQ-006.
REQ-015 With count = DEPTH-1, get_data_req SHALL be 0 even for a one-lane packet.
REQ-016 Entry contents SHALL never be modified except by enqueue; stale data beyond count is don't-care.

Reset
REQ-017 On cpu_rst = 1 at a clock edge: head = 0, tail = 0, count = 0; therefore out_valid = 00, get_data_req = 1 (when flush = 0).
REQ-018 Reset SHALL override flush, enqueue and dequeue in the same cycle; storage array need not be reset.

Structure
REQ-019 Entry struct typedef, DEPTH default, and exception-cause width (7) SHALL live in the shared front-end package.
REQ-020 One sub-module is natural: id_fetch_queue_ram (DEPTH x 112, two write ports at tail/tail+1, two async read ports at head/head+1); the remainder is pointer/count control.

Verification
REQ-021 Reset, then in_valid=1, lane_en=11, pc=0x1C000000/0x1C000004 -> next cycle out_valid=11, out_pc = same, count=2.
REQ-022 Fill with four 2-lane packets (DEPTH=8) while dec_accept=00 -> count=8, get_data_req=0, a fifth in_valid ignored; dec_accept=11 -> count=6, get_data_req=1.
REQ-023 lane_en=10 with pc1=0x1C000044 into empty queue -> count=1, out_valid=01, out_pc[0]=0x1C000044.
REQ-024 count=5, simultaneous 2-lane enqueue and dec_accept=01 -> count=6; pointer wrap past entry 7 preserves order across 20 packets.
REQ-025 count=6 with enqueue and dec_accept=11 in same cycle as flush=1 -> next cycle count=0, out_valid=00, get_data_req=1.
REQ-026 pause=1 with count=3, dec_accept=11 -> out_valid=00, count unchanged; exception flag and cause 0x0D on lane0 reappear unchanged at out_* after pause drops.
